mbist_march_ctrl: RTL and testbench
===================================

Name: mbist_march_ctrl

Overview:
- March C- BIST engine: the initiator that drives the single-port memory interface (write_read, address, wdata) and checks rdata against expected data.
- Sits between the top-level test sequencer (start/done/fail) and the memory under test, which may be a fault-injected memory.
- Logs the first miscompare and counts all miscompares.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- LAST_ADDR, 2**ADDR_WIDTH-1, highest address tested. N = LAST_ADDR+1 words.
- CNT_WIDTH, 16, width of err_count; saturates at max.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from PRE through DRAIN.
- done  out  1  one-cycle pulse at test end.
- fail  out  1  sticky; high once any miscompare occurs; cleared by next start or rst.
- fail_addr  out  ADDR_WIDTH  address of first miscompare.
- fail_syndrome  out  DATA_WIDTH  rdata XOR expected at first miscompare.
- err_count  out  CNT_WIDTH  total miscompares, saturating.
- write_read  out  1  1 = write, 0 = read; to memory.
- address  out  ADDR_WIDTH  to memory.
- wdata  out  DATA_WIDTH  to memory; leads its write by one cycle.
- rdata  in  DATA_WIDTH  from memory; valid 2 cycles after the read is issued.

Behaviour:
- Reset values: all outputs 0 (write_read=0, address=0, wdata=0); state IDLE.
- Memory timing contract:
  - Memory registers wdata one cycle early. wdata in cycle k must equal the data of the op whose write_read/address appear in cycle k+1.
  - Memory returns a read issued in cycle k on rdata during cycle k+2. The controller compares at the end of cycle k+2.
- March sequence, one op per cycle, no gaps. "0" = all-zeros word, "1" = all-ones word.
  - M0 up: w0.
  - M1 up: r0, w1 per address.
  - M2 up: r1, w0.
  - M3 down: r0, w1.
  - M4 down: r1, w0.
  - M5 up: r0.
  - Up runs 0..LAST_ADDR; down runs LAST_ADDR..0. Total ops = 10N.
- FSM:
  - IDLE: start=1 goes to PRE; clears fail, fail_addr, fail_syndrome, err_count.
  - PRE (1 cycle): wdata = 0 (data for the first M0 write); write_read=0.
  - RUN: issues the 10N ops. After the final M5 read, goes to DRAIN.
  - DRAIN (2 cycles): write_read=0, address held; pending compares complete.
  - Then DONE (1 cycle): done=1, busy=0. Then IDLE.
- done asserts on edge 10N+4 after the edge that sampled start.
- Compare pipeline:
  - 2-stage shift of {valid, addr, expected} tagged on read ops only.
  - Miscompare = valid and (rdata != expected).
  - The first miscompare latches fail_addr and fail_syndrome. Later ones only increment err_count.
  - Writes never generate compares.
- Outside RUN: write_read=0 (harmless reads), address=0.
- Boundaries:
  - start while busy: ignored.
  - start in the same cycle as done: ignored.
  - LAST_ADDR=0: sequence degenerates correctly (10 ops).
  - Up/down counters must not wrap past 0 or LAST_ADDR.
  - err_count stops at all-ones.
- rst mid-test: immediate return to IDLE, all outputs 0, pending compares discarded.

Test Plan:
- Fault-free memory, defaults (N=16), start pulse -> 160 ops; done on edge 164; fail=0; err_count=0; busy high exactly 163 cycles.
- Memory with bit 3 stuck-at-1 at address 5 (OR with 8'h08) -> fail=1; fail_addr=5; fail_syndrome=8'h08; err_count=3 (M1, M3, M5 r0 reads).
- Stuck bits 0 and 7 at address 15 plus bit 2 at address 0 -> first miscompare is M1 at address 0: fail_addr=0, fail_syndrome=8'h04; err_count=6.
- Timing check: monitor the bus -> every write's wdata equals the value driven one cycle earlier on wdata; element order and address direction match the March sequence.
- Assert rst at op 70, release, start again -> outputs 0 immediately on rst; second run completes cleanly with done on edge 164.
- start pulses during RUN and coincident with done -> ignored; no restart; single done pulse.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- BIST engine driving a single-port memory
// Issues one op per cycle, compares read data two cycles later, logs first miscompare.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 2**ADDR_WIDTH-1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_syndrome,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  ONE_C   = CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ONES    = '1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Position of an op in the march: element 0..5, address, and which op of the pair.
  typedef struct packed {
    logic [2:0]            elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ph;
  } pos_t;

  function automatic pos_t advance(input pos_t p);
    pos_t n;
    logic two_op;
    logic down;
    logic at_end;
    n      = p;
    two_op = (p.elem != 3'd0) && (p.elem != 3'd5);
    down   = (p.elem == 3'd3) || (p.elem == 3'd4);
    at_end = down ? (p.addr == '0) : (p.addr == LAST_A);
    if (two_op && !p.ph) begin
      n.ph = 1'b1;
    end else begin
      n.ph = 1'b0;
      if (at_end) begin
        n.elem = p.elem + 3'd1;
        n.addr = ((n.elem == 3'd3) || (n.elem == 3'd4)) ? LAST_A : '0;
      end else if (down) begin
        n.addr = p.addr - ONE_A;
      end else begin
        n.addr = p.addr + ONE_A;
      end
    end
    return n;
  endfunction

  function automatic logic op_is_write(input pos_t p);
    return (p.elem == 3'd0) || p.ph;
  endfunction

  // Write data for writes, expected data for reads.
  function automatic logic [DATA_WIDTH-1:0] op_data(input pos_t p);
    logic ones;
    if (op_is_write(p)) ones = (p.elem == 3'd1) || (p.elem == 3'd3);
    else                ones = (p.elem == 3'd2) || (p.elem == 3'd4);
    return ones ? ONES : '0;
  endfunction

  state_t                r_state;
  pos_t                  r_pos;
  logic                  r_armed;
  logic                  r_fin;
  logic                  r_drain;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_syn;
  logic [CNT_WIDTH-1:0]  r_err;
  logic                  r_write_read;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_cur_rd;
  logic [DATA_WIDTH-1:0] r_cur_exp;
  logic                  r_s1_vld, r_s2_vld;
  logic [ADDR_WIDTH-1:0] r_s1_addr, r_s2_addr;
  logic [DATA_WIDTH-1:0] r_s1_exp, r_s2_exp;

  pos_t                  w_n1;
  logic                  w_issue;
  logic                  w_miscmp;

  always_comb begin
    w_n1     = advance(r_pos);
    w_issue  = (r_state == S_PRE) || ((r_state == S_RUN) && !r_fin);
    w_miscmp = r_s2_vld && (rdata != r_s2_exp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pos        <= '0;
      r_armed      <= 1'b0;
      r_fin        <= 1'b0;
      r_drain      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_addr  <= '0;
      r_fail_syn   <= '0;
      r_err        <= '0;
      r_write_read <= 1'b0;
      r_address    <= '0;
      r_wdata      <= '0;
      r_cur_rd     <= 1'b0;
      r_cur_exp    <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_addr    <= '0;
      r_s1_exp     <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_addr    <= '0;
      r_s2_exp     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_s1_vld  <= r_cur_rd;
      r_s1_addr <= r_address;
      r_s1_exp  <= r_cur_exp;
      r_s2_vld  <= r_s1_vld;
      r_s2_addr <= r_s1_addr;
      r_s2_exp  <= r_s1_exp;

      if (w_miscmp) begin
        if (!r_fail) begin
          r_fail      <= 1'b1;
          r_fail_addr <= r_s2_addr;
          r_fail_syn  <= rdata ^ r_s2_exp;
        end
        if (r_err != '1) r_err <= r_err + ONE_C;
      end

      // wdata always carries the data of the op one step ahead of the bus.
      if (w_issue) begin
        r_state      <= S_RUN;
        r_write_read <= op_is_write(r_pos);
        r_address    <= r_pos.addr;
        r_wdata      <= op_data(w_n1);
        r_cur_rd     <= !op_is_write(r_pos);
        r_cur_exp    <= op_data(r_pos);
        r_fin        <= (r_pos.elem == 3'd5) && (r_pos.addr == LAST_A);
        r_pos        <= w_n1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_armed) begin
            r_armed <= 1'b0;
            r_state <= S_PRE;
            r_busy  <= 1'b1;
            r_wdata <= '0;
            r_pos   <= '0;
          end else if (start) begin
            r_armed     <= 1'b1;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_syn  <= '0;
            r_err       <= '0;
          end
        end
        S_RUN: begin
          if (r_fin) begin
            r_state      <= S_DRAIN;
            r_fin        <= 1'b0;
            r_drain      <= 1'b0;
            r_write_read <= 1'b0;
            r_wdata      <= '0;
            r_cur_rd     <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_address <= '0;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: ;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign fail          = r_fail;
  assign fail_addr     = r_fail_addr;
  assign fail_syndrome = r_fail_syn;
  assign err_count     = r_err;
  assign write_read    = r_write_read;
  assign address       = r_address;
  assign wdata         = r_wdata;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - bench for mbist_march_ctrl with a fault-injecting memory
// Expected bus ops and miscompare results come from a list-based march model.
module tb_mbist_march_ctrl;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, fail, write_read;
  logic [3:0]  fail_addr, address;
  logic [7:0]  fail_syndrome, wdata, rdata;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem  [N];
  logic [7:0] mask [N];
  logic [7:0] wd_q, rd1;

  int ex_wr[$];
  int ex_ad[$];
  int ex_dt[$];

  always #5 clk = ~clk;

  mbist_march_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_syndrome(fail_syndrome), .err_count(err_count),
    .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata)
  );

  // Memory: write data is the wdata seen one cycle before the write; reads return two cycles later.
  always @(posedge clk) begin
    if (write_read) mem[address] <= wd_q;
    rd1   <= mem[address] | mask[address];
    rdata <= rd1;
    wd_q  <= wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input int wr, input int a, input int d);
    ex_wr.push_back(wr);
    ex_ad.push_back(a);
    ex_dt.push_back(d);
  endtask

  task automatic build_ops();
    for (int a = 0; a < N; a++) push_op(1, a, 0);
    for (int a = 0; a < N; a++) begin push_op(0, a, 0);   push_op(1, a, 255); end
    for (int a = 0; a < N; a++) begin push_op(0, a, 255); push_op(1, a, 0);   end
    for (int a = N-1; a >= 0; a--) begin push_op(0, a, 0);   push_op(1, a, 255); end
    for (int a = N-1; a >= 0; a--) begin push_op(0, a, 255); push_op(1, a, 0);   end
    for (int a = 0; a < N; a++) push_op(0, a, 0);
  endtask

  task automatic model(output int cnt, output int fa, output int fs);
    int m [N];
    int v;
    cnt = 0; fa = 0; fs = 0;
    for (int k = 0; k < N; k++) m[k] = 0;
    for (int i = 0; i < ex_wr.size(); i++) begin
      if (ex_wr[i] == 1) begin
        m[ex_ad[i]] = ex_dt[i];
      end else begin
        v = m[ex_ad[i]] | int'(mask[ex_ad[i]]);
        if (v != ex_dt[i]) begin
          if (cnt == 0) begin fa = ex_ad[i]; fs = v ^ ex_dt[i]; end
          cnt++;
        end
      end
    end
  endtask

  task automatic clear_masks();
    for (int k = 0; k < N; k++) mask[k] = 8'h00;
  endtask

  task automatic run(input string tag, input bit pmid, input bit pdone,
                     input int efail, input int ea, input int es, input int ecnt);
    int busy_cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int i;
    logic [7:0] prev_wd = 8'h00;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 180; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c >= 2 && c < 2 + 10*N) begin
        i = c - 2;
        chk({tag, "_op_wr"}, 32'(write_read), 32'(ex_wr[i]));
        chk({tag, "_op_addr"}, 32'(address), 32'(ex_ad[i]));
        if (ex_wr[i] == 1) chk({tag, "_op_wdata"}, 32'(prev_wd), 32'(ex_dt[i]));
      end
      prev_wd = wdata;
      if (pmid && c == 50) start = 1'b1;
      if (pmid && c == 51) start = 1'b0;
      if (pdone && done) start = 1'b1;
      if (pdone && done_cyc >= 0 && c == done_cyc + 1) start = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(10*N + 4));
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(10*N + 3));
    chk({tag, "_fail"}, 32'(fail), 32'(efail));
    chk({tag, "_fail_addr"}, 32'(fail_addr), 32'(ea));
    chk({tag, "_fail_syn"}, 32'(fail_syndrome), 32'(es));
    chk({tag, "_err_count"}, 32'(err_count), 32'(ecnt));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
    chk({tag, "_fail_syn"}, 32'(fail_syndrome), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_write_read"}, 32'(write_read), 32'd0);
    chk({tag, "_address"}, 32'(address), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata), 32'd0);
  endtask

  initial begin
    int cnt, fa, fs, nf;
    rst = 1'b1;
    start = 1'b0;
    clear_masks();
    build_ops();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run("clean", 1'b1, 1'b1, 0, 0, 0, 0);

    mask[5] = 8'h08;
    run("sa_a5", 1'b0, 1'b0, 1, 5, 8'h08, 3);

    clear_masks();
    mask[15] = 8'h81;
    mask[0]  = 8'h04;
    run("sa_multi", 1'b0, 1'b0, 1, 0, 8'h04, 6);

    // Reset while op 70 is on the bus, after a miscompare has already been logged.
    clear_masks();
    mask[5] = 8'h08;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 72; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
    end
    chk("pre_rst_fail", 32'(fail), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 check_zero("mid_rst");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    clear_masks();
    run("after_rst", 1'b0, 1'b0, 0, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      clear_masks();
      nf = $urandom_range(1, 3);
      for (int k = 0; k < nf; k++) mask[$urandom_range(0, N-1)] = 8'($urandom_range(1, 255));
      model(cnt, fa, fs);
      run($sformatf("rand%0d", r), 1'b0, 1'b0, (cnt != 0) ? 1 : 0, fa, fs, cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
